// File: rtl/dtw_ctrl.sv
// dtw_ctrl: run sequencer that streams reference-ROM and camera samples into the dtw engine,
// supervises the run with a timeout and reports a latched score. Option macro: DTW_CTRL_THRESH_EN.
module dtw_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int SIZE       = 602,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ref_addr,
  input  logic [DATA_WIDTH-1:0] ref_rdata,
  input  logic                  cam_valid,
  input  logic [DATA_WIDTH-1:0] cam_data,
  output logic                  cam_ready,
  output logic                  dtw_ready,
  output logic [DATA_WIDTH-1:0] dtw_refer,
  output logic [DATA_WIDTH-1:0] dtw_camera,
  input  logic                  dtw_ready_refer,
  input  logic                  dtw_ready_camera,
  input  logic                  dtw_done,
  input  logic [DATA_WIDTH-1:0] dtw_score,
  output logic [DATA_WIDTH-1:0] score,
  output logic                  score_valid,
  output logic                  error
`ifdef DTW_CTRL_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  match
`endif
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         SIZE_C    = CW'(SIZE);
  localparam logic [TW-1:0]         TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME1,
    S_PRIME2,
    S_RUN,
    S_WAIT_DONE,
    S_REPORT,
    S_ERR
  } state_t;

  state_t                state;
  logic [CW-1:0]         ref_cnt;
  logic [CW-1:0]         cam_cnt;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         timer_inc;
  logic [DATA_WIDTH-1:0] ref_next;
  logic                  underflow;
  logic                  ref_take;

  // NOTE: pure continuous assigns for the request decode; nothing here can hold state, so no latch.
  assign cam_ready = (state == S_RUN) && dtw_ready_camera && (cam_cnt < SIZE_C);
  assign ref_take  = (state == S_RUN) && dtw_ready_refer && (ref_cnt < SIZE_C);
  assign timer_inc = timer + 1'b1;

  // ref_rdata is expected to reflect the current ref_addr, so ref_next always holds
  // the sample the engine will receive on its next reference request.
  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      ref_addr    <= '0;
      ref_next    <= '0;
      ref_cnt     <= '0;
      cam_cnt     <= '0;
      timer       <= '0;
      underflow   <= 1'b0;
      dtw_ready   <= 1'b0;
      dtw_refer   <= '0;
      dtw_camera  <= '0;
      score       <= '0;
      score_valid <= 1'b0;
      error       <= 1'b0;
`ifdef DTW_CTRL_THRESH_EN
      match       <= 1'b0;
`endif
    end else begin
      score_valid <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            ref_cnt   <= '0;
            cam_cnt   <= '0;
            timer     <= '0;
            underflow <= 1'b0;
            ref_addr  <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_PRIME1;
          end
        end

        S_PRIME1: state <= S_PRIME2;

        S_PRIME2: begin
          ref_next  <= ref_rdata;
          ref_addr  <= ADDR_WIDTH'(1);
          dtw_ready <= 1'b1;
          state     <= S_RUN;
        end

        S_RUN, S_WAIT_DONE: begin
          timer <= timer_inc;
          if (ref_take) begin
            dtw_refer <= ref_next;
            ref_next  <= ref_rdata;
            ref_cnt   <= ref_cnt + 1'b1;
            if (ref_addr != ADDR_MAX) ref_addr <= ref_addr + 1'b1;
          end
          // The engine cannot stall, so a missing camera sample still burns its slot.
          if (cam_ready) begin
            if (cam_valid) dtw_camera <= cam_data;
            else           underflow  <= 1'b1;
            cam_cnt <= cam_cnt + 1'b1;
          end

          if (dtw_done) begin
            score       <= dtw_score;
            score_valid <= 1'b1;
            dtw_ready   <= 1'b0;
            state       <= S_REPORT;
          end else if (timer_inc >= TIMEOUT_C) begin
            dtw_ready <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
`ifdef DTW_CTRL_THRESH_EN
            match     <= 1'b0;
`endif
            state     <= S_ERR;
          end else if (state == S_RUN && ref_cnt == SIZE_C && cam_cnt == SIZE_C) begin
            state <= S_WAIT_DONE;
          end
        end

        S_REPORT: begin
          busy <= 1'b0;
`ifdef DTW_CTRL_THRESH_EN
          match <= (score <= threshold) && !underflow;
`endif
          if (underflow) begin
            error <= 1'b1;
            state <= S_ERR;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          busy      <= 1'b0;
          dtw_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
